// File: rtl/oram_block_frontend_adapter_if.sv
// Host request/response bus plus the Path ORAM frontend command/data bus.
// Latency: none, wiring only.
// Backpressure: valid/ready on every channel; 'slave' is the adapter, 'master' its environment.
interface oram_block_frontend_adapter_if #(
  parameter int ORAMB    = 512,
  parameter int ORAMU    = 32,
  parameter int FEDWidth = 32
);
  // Host side: one whole block per handshake
  logic [1:0]          HCmd;
  logic [ORAMU-1:0]    HAddr;
  logic [ORAMB-1:0]    HData;
  logic                HCmdValid;
  logic                HCmdReady;
  logic [ORAMB-1:0]    HRespData;
  logic                HRespValid;
  logic                HRespReady;
  // ORAM side: command plus FEDWidth-wide data beats
  logic [1:0]          Cmd;
  logic [ORAMU-1:0]    PAddr;
  logic                CmdValid;
  logic                CmdReady;
  logic [FEDWidth-1:0] DataIn;
  logic                DataInValid;
  logic                DataInReady;
  logic [FEDWidth-1:0] DataOut;
  logic                DataOutValid;
  logic                DataOutReady;

  modport slave (
    input  HCmd, HAddr, HData, HCmdValid, HRespReady,
    output HCmdReady, HRespData, HRespValid,
    output Cmd, PAddr, CmdValid, DataIn, DataInValid, DataOutReady,
    input  CmdReady, DataInReady, DataOut, DataOutValid
  );

  modport master (
    output HCmd, HAddr, HData, HCmdValid, HRespReady,
    input  HCmdReady, HRespData, HRespValid,
    input  Cmd, PAddr, CmdValid, DataIn, DataInValid, DataOutReady,
    output CmdReady, DataInReady, DataOut, DataOutValid
  );
endinterface

// File: rtl/oram_block_frontend_adapter.sv
// Host-to-ORAM block adapter: one command, then Chunks write beats out or Chunks read beats in.
// Latency: command 1 cycle after host accept; write 2+Chunks cycles, read 3+Chunks with response.
// Backpressure: one request in flight; CmdReady/DataInReady/DataOutValid/HRespReady low simply stall.
module oram_block_frontend_adapter #(
  parameter int ORAMB    = 512,
  parameter int ORAMU    = 32,
  parameter int FEDWidth = 32
) (
  input  logic                          Clock,
  input  logic                          Reset,
  oram_block_frontend_adapter_if.slave  bus,
  output logic                          Busy,
  output logic                          ErrStray
);

  localparam int Chunks = ORAMB / FEDWidth;
  localparam int CW     = $clog2(Chunks) + 1;
  localparam logic [CW-1:0] LastBeat = CW'(Chunks - 1);

  typedef enum logic [2:0] {
    ST_Idle,
    ST_Cmd,
    ST_Write,
    ST_Read,
    ST_Resp
  } state_t;

  state_t           state;
  logic [1:0]       cmdReg;
  logic [ORAMU-1:0] addrReg;
  logic [ORAMB-1:0] shiftReg;    // write block, MS slice is the current beat
  logic [ORAMB-1:0] accReg;      // read block, first beat ends up in the MSBs
  logic [CW-1:0]    beatCnt;
  logic             hCmdRdy;
  logic             cmdVld;
  logic             dinVld;
  logic             doutRdy;
  logic             respVld;
  logic             errStray;

  // Data/address outputs come straight from the holding registers, so they
  // are stable for as long as the matching valid is high.
  assign bus.HCmdReady    = hCmdRdy;
  assign bus.Cmd          = cmdReg;
  assign bus.PAddr        = addrReg;
  assign bus.CmdValid     = cmdVld;
  assign bus.DataIn       = shiftReg[ORAMB-1 -: FEDWidth];
  assign bus.DataInValid  = dinVld;
  assign bus.DataOutReady = doutRdy;
  assign bus.HRespData    = accReg;
  assign bus.HRespValid   = respVld;
  assign Busy             = (state != ST_Idle);
  assign ErrStray         = errStray;

  // Request FSM with registered handshake outputs; reset aborts any transfer.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= ST_Idle;
      cmdReg   <= '0;
      addrReg  <= '0;
      shiftReg <= '0;
      accReg   <= '0;
      beatCnt  <= '0;
      hCmdRdy  <= 1'b0;
      cmdVld   <= 1'b0;
      dinVld   <= 1'b0;
      doutRdy  <= 1'b0;
      respVld  <= 1'b0;
      errStray <= 1'b0;
    end else begin
      // Read beats are only consumed in ST_Read; anything else is a protocol error.
      if (bus.DataOutValid && state != ST_Read) begin
        errStray <= 1'b1;
      end
      case (state)
        ST_Idle: begin
          if (bus.HCmdValid && hCmdRdy) begin
            cmdReg   <= bus.HCmd;
            addrReg  <= bus.HAddr;
            shiftReg <= bus.HData;
            beatCnt  <= '0;
            hCmdRdy  <= 1'b0;
            cmdVld   <= 1'b1;
            state    <= ST_Cmd;
          end else begin
            hCmdRdy <= 1'b1;
          end
        end
        ST_Cmd: begin
          if (bus.CmdReady) begin
            cmdVld <= 1'b0;
            // Update(0)/Append(1) carry data out; Read(2)/ReadRmv(3) bring data back.
            if (!cmdReg[1]) begin
              dinVld <= 1'b1;
              state  <= ST_Write;
            end else begin
              doutRdy <= 1'b1;
              state   <= ST_Read;
            end
          end
        end
        ST_Write: begin
          if (bus.DataInReady) begin
            shiftReg <= shiftReg << FEDWidth;
            beatCnt  <= beatCnt + CW'(1);
            if (beatCnt == LastBeat) begin
              dinVld  <= 1'b0;
              hCmdRdy <= 1'b1;
              state   <= ST_Idle;
            end
          end
        end
        ST_Read: begin
          if (bus.DataOutValid) begin
            accReg  <= {accReg[ORAMB-FEDWidth-1:0], bus.DataOut};
            beatCnt <= beatCnt + CW'(1);
            if (beatCnt == LastBeat) begin
              doutRdy <= 1'b0;
              respVld <= 1'b1;
              state   <= ST_Resp;
            end
          end
        end
        ST_Resp: begin
          if (bus.HRespReady) begin
            respVld <= 1'b0;
            hCmdRdy <= 1'b1;
            state   <= ST_Idle;
          end
        end
        default: state <= ST_Idle;
      endcase
    end
  end

endmodule

// File: doc/oram_block_frontend_adapter.md
Name: oram_block_frontend_adapter

Overview:
- Host-side adapter directly upstream of the Path ORAM top-level frontend interface.
- Host side: one whole-block request per handshake (command, address, full ORAMB-bit block).
- ORAM side: drives Cmd/PAddr/CmdValid, serializes write blocks into FEDWidth beats, and deserializes returned read data into a full block for the host.
- Serves as the synthesizable replacement for bench-driven request streams in on-FPGA ORAM regression.

Parameters:
- ORAMB, 512, block size in bits; must be an integer multiple of FEDWidth.
- ORAMU, 32, program address width.
- FEDWidth, 32, frontend data beat width.
- Chunks (localparam), ORAMB/FEDWidth, beats per block. Default is 16.
- CW (localparam), `log2(Chunks)+1, beat counter width.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-low
- HCmd  in  2  0 Update, 1 Append, 2 Read, 3 ReadRmv
- HAddr  in  ORAMU  block address
- HData  in  ORAMB  write block, used for Update/Append only
- HCmdValid  in  1  host request valid
- HCmdReady  out  1  adapter can accept a request
- HRespData  out  ORAMB  assembled read block
- HRespValid  out  1  read block valid
- HRespReady  in  1  host accepts the read block
- Cmd  out  2  command to ORAM
- PAddr  out  ORAMU  address to ORAM
- CmdValid  out  1  command valid
- CmdReady  in  1  ORAM accepts the command
- DataIn  out  FEDWidth  write beat
- DataInValid  out  1  write beat valid
- DataInReady  in  1  ORAM accepts the write beat
- DataOut  in  FEDWidth  read beat
- DataOutValid  in  1  read beat valid
- DataOutReady  out  1  adapter accepts the read beat
- Busy  out  1  high whenever the state is not ST_Idle
- ErrStray  out  1  sticky; set when DataOutValid is seen outside ST_Read

Behaviour:
- Reset: Reset is synchronous, active-low; clock is Clock.
- Values while Reset==0 at a Clock edge:
  - state = ST_Idle.
  - All valid outputs = 0; DataOutReady = 0; ErrStray = 0; beat counter = 0.
  - HRespData, DataIn, Cmd, PAddr = 0.
- Reset asserted mid-operation aborts the in-flight request immediately. No partial beats continue and no response is produced.
- The FSM has five states: ST_Idle, ST_Cmd, ST_Write, ST_Read, ST_Resp.
- ST_Idle:
  - HCmdReady = 1 in this state only.
  - On HCmdValid&&HCmdReady: latch HCmd, HAddr and HData into internal registers, clear the counter, go to ST_Cmd.
- ST_Cmd:
  - CmdValid = 1, with Cmd and PAddr driven from the latched registers.
  - Hold until CmdReady. Cmd/PAddr must stay stable while CmdValid is high.
  - On the handshake: Update or Append → ST_Write; Read or ReadRmv → ST_Read.
- ST_Write:
  - DataInValid = 1.
  - DataIn = most-significant FEDWidth slice of the latched block shift register.
  - On each DataInReady: shift the register left by FEDWidth and increment the counter.
  - After beat Chunks is accepted → ST_Idle.
  - DataInReady low stalls the transfer; DataIn is held.
- ST_Read:
  - DataOutReady = 1.
  - On each DataOutValid: accumulator = (accumulator << FEDWidth) | DataOut, so the first beat lands in the MSBs. Increment the counter.
  - On beat Chunks → ST_Resp.
- ST_Resp:
  - HRespValid = 1, with HRespData = accumulator held stable.
  - On HRespReady → ST_Idle.
- Latency, counting the host accept edge as cycle 0:
  - CmdValid rises at cycle 1.
  - First DataInValid is in the cycle after the command handshake.
  - HRespValid rises in the cycle after the last read beat is accepted.
  - Minimum write = 2+Chunks cycles; minimum read = 3+Chunks cycles, including the response handshake.
- No back-to-back overlap: the next host request is accepted only in ST_Idle. Throughput is one request in flight.
- DataOutValid in any state other than ST_Read: not consumed (DataOutReady=0) and ErrStray set. ErrStray clears only on reset.
- Counter is CW bits; compare against Chunks. It never wraps within a request.

Test Plan:
- Reset: hold Reset=0 for 5 cycles with HCmdValid=1 → all valids 0, HCmdReady=0, Busy=0, ErrStray=0. After release, HCmdReady=1 in the next cycle.
- Append addr 0x5, HData={16 beats 0x0F..0x00}, CmdReady and DataInReady always 1:
  - Cmd=1 and PAddr=5 on cycle 1.
  - DataIn sequence 0x0F,0x0E,…,0x00 on cycles 2–17.
  - HCmdReady returns at cycle 18.
- Read addr 0x5 with DataOut beats 0x0F..0x00 and a stall in which DataOutValid is low for 3 cycles mid-burst → HRespData equals the appended block exactly; HRespValid held until HRespReady.
- Backpressure: CmdReady low for 10 cycles, then DataInReady toggling 1/0 → Cmd, PAddr and DataIn stable while stalled; exactly 16 beats transferred; no duplicate beats and no dropped beats.
- DataOutValid pulsed while in ST_Idle → ErrStray=1 from the next cycle and stays high; no state change.
- Reset mid-ST_Write after beat 7 → next cycle is ST_Idle with DataInValid=0. A subsequent Update to addr 9 completes normally with 16 beats.
